// File: rtl/spc_pcx_tx_rpt_if.sv
// ---------------------------------------------------------------------------
// spc_pcx_tx_rpt_if
//   Bundles the core-side request handshake and the PCX request/packet/grant
//   signals of the SPC->PCX transmit repeater.
//   master : core + crossbar side (drives requests and grants)
//   slave  : the transmit repeater (drives rdy, req_pq, atom_pq, data_pa)
// ---------------------------------------------------------------------------
interface spc_pcx_tx_rpt_if #(
    parameter int NDEST = 5,
    parameter int PKT_W = 124
);
    logic             core_req_vld;
    logic [NDEST-1:0] core_req_dest;
    logic             core_req_atom;
    logic [PKT_W-1:0] core_req_data;
    logic             core_req_rdy;
    logic [NDEST-1:0] spc_pcx_req_pq;
    logic             spc_pcx_atom_pq;
    logic [PKT_W-1:0] spc_pcx_data_pa;
    logic [NDEST-1:0] pcx_spc_grant_px;

    modport master (
        output core_req_vld, core_req_dest, core_req_atom, core_req_data,
        output pcx_spc_grant_px,
        input  core_req_rdy, spc_pcx_req_pq, spc_pcx_atom_pq, spc_pcx_data_pa
    );

    modport slave (
        input  core_req_vld, core_req_dest, core_req_atom, core_req_data,
        input  pcx_spc_grant_px,
        output core_req_rdy, spc_pcx_req_pq, spc_pcx_atom_pq, spc_pcx_data_pa
    );
endinterface

// File: rtl/spc_pcx_tx_rpt.sv
// ---------------------------------------------------------------------------
// spc_pcx_tx_rpt
//   Outbound SPC->PCX transmit buffer/repeater. Core packets are queued in a
//   DEPTH-entry FIFO and issued in strict order: a one-hot request pulse in
//   PQ (flopped), then the packet in PA one cycle later. Per-destination
//   outstanding counters limit unacknowledged requests to MAX_OUT and are
//   retired by pcx_spc_grant_px. Atomic pairs issue back to back.
// Ports
//   rclk, reset  : clock, synchronous active-high reset
//   bus (slave)  : core_req_* handshake in, spc_pcx_req_pq/atom_pq/data_pa
//                  out, pcx_spc_grant_px in
//   pcx_tx_err   : sticky protocol-error flag
// Build option
//   PCX_TX_ERR_CHK_EN : when defined, pcx_tx_err flags grant-without-
//   outstanding, push while not ready, non-one-hot dest and atomic-pair
//   dest mismatch. When undefined, pcx_tx_err is tied low.
// ---------------------------------------------------------------------------
module spc_pcx_tx_rpt #(
    parameter int DEPTH   = 4,
    parameter int PKT_W   = 124,
    parameter int NDEST   = 5,
    parameter int MAX_OUT = 2
) (
    input  logic                  rclk,
    input  logic                  reset,
    spc_pcx_tx_rpt_if.slave       bus,
    output logic                  pcx_tx_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   TWO  = (AW+1)'(2);
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUT);

    typedef struct packed {
        logic             atom;
        logic [NDEST-1:0] dest;
        logic [PKT_W-1:0] data;
    } entry_t;

    // ISSUE: a normal/second-half request was loaded this cycle;
    // ATOM2: a first half was loaded, its partner must follow unconditionally.
    typedef enum logic [1:0] {IDLE, ISSUE, ATOM2} state_t;

    entry_t                      mem [DEPTH];
    logic   [AW-1:0]             rd_ptr, wr_ptr;
    logic   [AW:0]               count, count_nxt;
    logic                        rdy_q;
    logic   [NDEST-1:0][CW-1:0]  out_cnt;
    logic   [NDEST-1:0]          cnt_nz, inc, dec;
    state_t                      state, state_nxt;

    logic   [NDEST-1:0]          req_q, req_nxt;
    logic                        atom_q, atom_nxt;
    logic                        pq_vld;
    logic   [PKT_W-1:0]          pq_data, pa_q;

    entry_t                      head;
    logic                        push, pop, credit_ok, drained_ok;

    assign head = mem[rd_ptr];
    assign push = bus.core_req_vld & rdy_q;

    // Credit view of the head's destination(s).
    always_comb begin
        credit_ok  = 1'b1;
        drained_ok = 1'b1;
        for (int i = 0; i < NDEST; i++) begin
            cnt_nz[i] = (out_cnt[i] != '0);
            if (head.dest[i]) begin
                if (out_cnt[i] >= CMAX) credit_ok  = 1'b0;
                if (cnt_nz[i])          drained_ok = 1'b0;
            end
        end
    end

    // Issue FSM: decides the pop and the next PQ outputs.
    always_comb begin
        state_nxt = IDLE;
        pop       = 1'b0;
        req_nxt   = '0;
        atom_nxt  = 1'b0;
        if (state == ATOM2)
            pop = 1'b1;                 // partner was present when the first half issued
        else if (count != '0)
            pop = head.atom ? (drained_ok && (count >= TWO)) : credit_ok;
        if (pop) begin
            req_nxt   = head.dest;
            atom_nxt  = head.atom & (state != ATOM2);
            state_nxt = atom_nxt ? ATOM2 : ISSUE;
        end
    end

    assign count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_ff @(posedge rclk) begin
        if (push) mem[wr_ptr] <= '{atom: bus.core_req_atom,
                                   dest: bus.core_req_dest,
                                   data: bus.core_req_data};
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rdy_q   <= 1'b0;
            state   <= IDLE;
            req_q   <= '0;
            atom_q  <= 1'b0;
            pq_vld  <= 1'b0;
            pq_data <= '0;
            pa_q    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_nxt;
            rdy_q   <= (count_nxt < FULL);
            state   <= state_nxt;
            req_q   <= req_nxt;
            atom_q  <= atom_nxt;
            pq_vld  <= pop;
            pq_data <= head.data;
            pa_q    <= pq_vld ? pq_data : '0;
        end
    end

    // Outstanding counters: issue and grant in the same cycle cancel;
    // a grant to an idle destination is dropped.
    assign inc = pop ? head.dest : '0;
    assign dec = bus.pcx_spc_grant_px & cnt_nz;

    always_ff @(posedge rclk) begin
        for (int i = 0; i < NDEST; i++) begin
            if (reset)
                out_cnt[i] <= '0;
            else if (inc[i] & ~dec[i])
                out_cnt[i] <= out_cnt[i] + CW'(1);
            else if (dec[i] & ~inc[i])
                out_cnt[i] <= out_cnt[i] - CW'(1);
        end
    end

    assign bus.core_req_rdy    = rdy_q;
    assign bus.spc_pcx_req_pq  = req_q;
    assign bus.spc_pcx_atom_pq = atom_q;
    assign bus.spc_pcx_data_pa = pa_q;

`ifdef PCX_TX_ERR_CHK_EN
    logic             err_q, err_set, last_atom, dest_onehot;
    logic [NDEST-1:0] last_dest;

    always_comb begin
        dest_onehot = (bus.core_req_dest != '0) &&
                      ((bus.core_req_dest & (bus.core_req_dest - NDEST'(1))) == '0);
        err_set = (|(bus.pcx_spc_grant_px & ~cnt_nz))
                | (bus.core_req_vld & ~rdy_q)
                | (bus.core_req_vld & ~dest_onehot)
                | (push & last_atom & (bus.core_req_dest != last_dest));
    end

    // last_atom remembers that the previous push opened an atomic pair.
    always_ff @(posedge rclk) begin
        if (reset) begin
            err_q     <= 1'b0;
            last_atom <= 1'b0;
            last_dest <= '0;
        end else begin
            if (err_set) err_q <= 1'b1;
            if (push) begin
                last_atom <= bus.core_req_atom;
                last_dest <= bus.core_req_dest;
            end
        end
    end

    assign pcx_tx_err = err_q;
`else
    assign pcx_tx_err = 1'b0;
`endif

endmodule
